multicycle_decoder: RTL and testbench
=====================================

# multicycle_decoder

Main control unit for the multicycle ARM datapath: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback cycles. It also contains the ALU/flag decoder and the PC-write logic. Its strobes (PCS, RegW, MemW, FlagW) feed the conditional-execution unit, which gates them with the condition check before they reach architectural state. It also drives all datapath mux selects and enables.

## Interface
- No parameters.
- CLK  in  1  rising-edge clock
- RESET  in  1  asynchronous, active-high reset
- Op  in  2  instruction bits [27:26], taken from the instruction register
- Funct  in  6  instruction bits [25:20]: I, cmd[3:0], S/L
- Rd  in  4  instruction bits [15:12]
- PCS  out  1  PC-write request (branch, or register write to R15)
- RegW  out  1  register-file write strobe
- MemW  out  1  data-memory write strobe
- FlagW  out  2  [1] update N,Z; [0] update C,V
- IRWrite  out  1  instruction-register load
- NextPC  out  1  unconditional PC load (fetch increment)
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALU result register
- ALUSrcA  out  1  0 = register A, 1 = PC
- ALUSrcB  out  2  00 = register B, 01 = extended immediate, 10 = constant 4
- ResultSrc  out  2  00 = ALUOut, 01 = data register, 10 = ALU result
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- ImmSrc  out  2  equals Op
- RegSrc  out  2  [0] = (Op==10), [1] = (Op==01)
- State  out  4  current state encoding, for debug and verification

## Operation
- State encodings and transitions:
  - FETCH = 0 → DECODE.
  - DECODE = 1 → MEMADR if Op=01.
  - DECODE → EXECR if Op=00 and Funct[5]=0.
  - DECODE → EXECI if Op=00 and Funct[5]=1.
  - DECODE → BRANCH if Op=10.
  - DECODE → FETCH if Op=11 (illegal; no strobes are asserted).
  - MEMADR = 2 → MEMREAD if Funct[0]=1, else → MEMWRITE.
  - MEMREAD = 3 → MEMWB.
  - MEMWB = 4 → FETCH.
  - MEMWRITE = 5 → FETCH.
  - EXECR = 6 and EXECI = 7 → FETCH if cmd=1010 (CMP), else → ALUWB.
  - ALUWB = 8 → FETCH.
  - BRANCH = 9 → FETCH.
  - Encodings 10–15 are unreachable and → FETCH.
- Moore outputs per state. Any field not listed is 0 (selects = 00, ALUControl = ADD).
  - FETCH: IRWrite=1, NextPC=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMREAD: AdrSrc=1.
  - MEMWRITE: AdrSrc=1, MemW=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - EXECR: ALUSrcB=00, ALU decode enabled.
  - EXECI: ALUSrcB=01, ALU decode enabled.
  - ALUWB: RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
- ALU decode applies in EXECR/EXECI only:
  - cmd 0100 → ADD; 0010 → SUB; 0000 → AND; 1100 → ORR; 1010 (CMP) → SUB.
  - Any other cmd → ADD with FlagW=00.
  - FlagW[1] = S; FlagW[0] = S and (ADD or SUB).
  - CMP forces FlagW=11 regardless of S.
- PCS = Branch | (RegW & Rd==4'b1111).
- ImmSrc and RegSrc are combinational from Op in every state.

## Timing
- State register updates on the CLK rising edge. All outputs are combinational from State, Op, Funct and Rd; there are no registered outputs.
- Reset behaviour:
  - RESET high forces State=FETCH immediately.
  - While RESET is high, IRWrite, NextPC, RegW, MemW, PCS and FlagW are forced to 0. Selects take their FETCH values.
  - The first fetch occurs on the first rising edge after RESET deasserts.
  - Reset asserted mid-instruction aborts it with no further strobes.
- Op, Funct and Rd are valid from DECODE onward, since IR loads at the end of FETCH. Their values in FETCH must not affect any strobe.
- Cycles per instruction, from FETCH to the next FETCH:
  - LDR 5; STR 4; data-processing 4; CMP 3; B 3; illegal 2.
- Every strobe is high for exactly one cycle per instruction.

## Test plan
- Reset: RESET pulse mid-MEMWRITE → State=0 asynchronously, MemW=0 at once. After release: IRWrite=1, NextPC=1 for one cycle, then State=1.
- LDR R2 (Op=01, Funct=011001, Rd=0010) → State sequence 0,1,2,3,4,0. RegW=1 only in state 4 with ResultSrc=01. PCS=0.
- STR (Funct=011000) → sequence 0,1,2,5,0. MemW=1 only in state 5 with AdrSrc=1.
- ADDS R15, R1, #4 (Op=00, Funct=101001, Rd=1111):
  - EXECI: ALUControl=00, FlagW=11.
  - ALUWB: RegW=1 and PCS=1.
- CMP R1, R2 (Funct=010101) → sequence 0,1,6,0. ALUControl=01, FlagW=11, RegW never asserted.
- Op=10 → sequence 0,1,9,0 with PCS=1 in state 9. Op=11 → sequence 0,1,0 with all strobes 0 after FETCH.

Source files
------------

// File: rtl/multicycle_decoder_if.sv
// Bus between the multicycle ARM control unit and its datapath.
// Instruction fields (Op, Funct, Rd) flow from the instruction register
// into the decoder; strobes, mux selects and debug state flow back out.
//   master : datapath side, drives instruction fields, receives controls
//   slave  : decoder side, receives instruction fields, drives controls
interface multicycle_decoder_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic [1:0] FlagW;
  logic       IRWrite;
  logic       NextPC;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ALUControl;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic [3:0] State;

  modport master (
    output Op, Funct, Rd,
    input  PCS, RegW, MemW, FlagW, IRWrite, NextPC, AdrSrc, ALUSrcA,
           ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc, State
  );

  modport slave (
    input  Op, Funct, Rd,
    output PCS, RegW, MemW, FlagW, IRWrite, NextPC, AdrSrc, ALUSrcA,
           ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc, State
  );
endinterface

// File: rtl/multicycle_decoder.sv
// Main control unit of the multicycle ARM datapath. A Moore FSM walks each
// instruction through fetch/decode/execute/memory/writeback; an ALU/flag
// decoder is active in the execute states, and PCS requests a PC write on
// branches or register writes to R15.
// Ports:
//   CLK   : rising-edge clock
//   RESET : asynchronous active-high reset (state -> FETCH, strobes off)
//   bus   : slave side of multicycle_decoder_if (Op/Funct/Rd in; strobes,
//           selects, ALUControl, ImmSrc, RegSrc and State out)
module multicycle_decoder (
  input logic                   CLK,
  input logic                   RESET,
  multicycle_decoder_if.slave   bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t state;

  logic [3:0] cmd;
  logic       s_bit;
  assign cmd   = bus.Funct[4:1];
  assign s_bit = bus.Funct[0];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:    state <= DECODE;
        DECODE: begin
          case (bus.Op)
            2'b00:   state <= bus.Funct[5] ? EXECI : EXECR;
            2'b01:   state <= MEMADR;
            2'b10:   state <= BRANCH;
            default: state <= FETCH;
          endcase
        end
        MEMADR:   state <= bus.Funct[0] ? MEMREAD : MEMWRITE;
        MEMREAD:  state <= MEMWB;
        MEMWB:    state <= FETCH;
        MEMWRITE: state <= FETCH;
        EXECR,
        EXECI:    state <= (cmd == 4'b1010) ? FETCH : ALUWB;
        ALUWB:    state <= FETCH;
        BRANCH:   state <= FETCH;
        default:  state <= FETCH;
      endcase
    end
  end

  // Raw Moore strobes before reset gating
  logic       irwrite_m;
  logic       nextpc_m;
  logic       regw_m;
  logic       memw_m;
  logic       branch_m;
  logic       aludec_m;
  logic [1:0] alu_ctl;
  logic [1:0] flagw_dec;

  always_comb begin
    irwrite_m     = 1'b0;
    nextpc_m      = 1'b0;
    regw_m        = 1'b0;
    memw_m        = 1'b0;
    branch_m      = 1'b0;
    aludec_m      = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.ALUSrcA   = 1'b0;
    bus.ALUSrcB   = 2'b00;
    bus.ResultSrc = 2'b00;
    case (state)
      FETCH: begin
        irwrite_m     = 1'b1;
        nextpc_m      = 1'b1;
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      DECODE: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      MEMADR:   bus.ALUSrcB = 2'b01;
      MEMREAD:  bus.AdrSrc  = 1'b1;
      MEMWRITE: begin
        bus.AdrSrc = 1'b1;
        memw_m     = 1'b1;
      end
      MEMWB: begin
        bus.ResultSrc = 2'b01;
        regw_m        = 1'b1;
      end
      EXECR:    aludec_m = 1'b1;
      EXECI: begin
        bus.ALUSrcB = 2'b01;
        aludec_m    = 1'b1;
      end
      ALUWB:    regw_m = 1'b1;
      BRANCH: begin
        bus.ALUSrcB   = 2'b01;
        bus.ResultSrc = 2'b10;
        branch_m      = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU/flag decode; unrecognised commands fall back to ADD with no flag update
  always_comb begin
    alu_ctl   = 2'b00;
    flagw_dec = 2'b00;
    if (aludec_m) begin
      case (cmd)
        4'b0100: begin alu_ctl = 2'b00; flagw_dec = {s_bit, s_bit}; end
        4'b0010: begin alu_ctl = 2'b01; flagw_dec = {s_bit, s_bit}; end
        4'b0000: begin alu_ctl = 2'b10; flagw_dec = {s_bit, 1'b0};  end
        4'b1100: begin alu_ctl = 2'b11; flagw_dec = {s_bit, 1'b0};  end
        4'b1010: begin alu_ctl = 2'b01; flagw_dec = 2'b11;          end
        default: begin alu_ctl = 2'b00; flagw_dec = 2'b00;          end
      endcase
    end
  end

  // Strobes are masked combinationally so reset silences them immediately
  assign bus.IRWrite    = irwrite_m & ~RESET;
  assign bus.NextPC     = nextpc_m & ~RESET;
  assign bus.RegW       = regw_m & ~RESET;
  assign bus.MemW       = memw_m & ~RESET;
  assign bus.FlagW      = flagw_dec & {2{~RESET}};
  assign bus.PCS        = (branch_m | (regw_m & (bus.Rd == 4'b1111))) & ~RESET;
  assign bus.ALUControl = alu_ctl;
  assign bus.ImmSrc     = bus.Op;
  assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};
  assign bus.State      = state;

endmodule

// File: tb/tb_multicycle_decoder.sv
module tb_multicycle_decoder;

  logic CLK = 1'b0;
  logic RESET = 1'b1;

  multicycle_decoder_if bus();

  multicycle_decoder dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] state;
    logic       pcs;
    logic       regw;
    logic       memw;
    logic [1:0] flagw;
    logic       irwrite;
    logic       nextpc;
    logic       adrsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic [1:0] alucontrol;
    logic [1:0] immsrc;
    logic [1:0] regsrc;
  } obs_t;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    int unsigned ncyc;
    logic [3:0]  seq [5];
    logic [1:0]  alu;
    logic [1:0]  flagw;
    logic [3:0]  pcs_at;   // state in which PCS is expected, 15 = never
  } vec_t;

  vec_t vecs[$];
  obs_t exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic add(input string name, input logic [1:0] op, input logic [5:0] funct,
                     input logic [3:0] rd, input int unsigned ncyc,
                     input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                     input logic [3:0] s3, input logic [3:0] s4,
                     input logic [1:0] alu, input logic [1:0] flagw, input logic [3:0] pcs_at);
    vec_t v;
    v.name = name; v.op = op; v.funct = funct; v.rd = rd; v.ncyc = ncyc;
    v.seq[0] = s0; v.seq[1] = s1; v.seq[2] = s2; v.seq[3] = s3; v.seq[4] = s4;
    v.alu = alu; v.flagw = flagw; v.pcs_at = pcs_at;
    vecs.push_back(v);
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.state      = bus.State;
    o.pcs        = bus.PCS;
    o.regw       = bus.RegW;
    o.memw       = bus.MemW;
    o.flagw      = bus.FlagW;
    o.irwrite    = bus.IRWrite;
    o.nextpc     = bus.NextPC;
    o.adrsrc     = bus.AdrSrc;
    o.alusrca    = bus.ALUSrcA;
    o.alusrcb    = bus.ALUSrcB;
    o.resultsrc  = bus.ResultSrc;
    o.alucontrol = bus.ALUControl;
    o.immsrc     = bus.ImmSrc;
    o.regsrc     = bus.RegSrc;
    return o;
  endfunction

  // Expected outputs for cycle c of vector v, from the per-state output table
  function automatic obs_t expect_for(input vec_t v, input int unsigned c, input logic [1:0] op);
    obs_t e;
    logic [3:0] s;
    s = v.seq[c];
    e.state      = s;
    e.irwrite    = (s == 4'd0);
    e.nextpc     = (s == 4'd0);
    e.adrsrc     = (s == 4'd3) || (s == 4'd5);
    e.alusrca    = (s == 4'd0) || (s == 4'd1);
    e.alusrcb    = ((s == 4'd0) || (s == 4'd1)) ? 2'b10 :
                   ((s == 4'd2) || (s == 4'd7) || (s == 4'd9)) ? 2'b01 : 2'b00;
    e.resultsrc  = ((s == 4'd0) || (s == 4'd1) || (s == 4'd9)) ? 2'b10 :
                   (s == 4'd4) ? 2'b01 : 2'b00;
    e.regw       = (s == 4'd4) || (s == 4'd8);
    e.memw       = (s == 4'd5);
    e.flagw      = ((s == 4'd6) || (s == 4'd7)) ? v.flagw : 2'b00;
    e.alucontrol = ((s == 4'd6) || (s == 4'd7)) ? v.alu : 2'b00;
    e.pcs        = (s == v.pcs_at);
    e.immsrc     = op;
    e.regsrc     = {op == 2'b01, op == 2'b10};
    return e;
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // Called at posedge+1 with the DUT in FETCH; runs ncyc cycles of vector idx.
  // Instruction fields are randomised during FETCH, since they must not matter there.
  task automatic run_vec(input int unsigned idx, input int unsigned ncyc);
    vec_t v;
    obs_t got, e;
    v = vecs[idx];
    for (int unsigned c = 0; c < ncyc; c++) begin
      if (c == 0) begin
        bus.Op    = 2'($urandom);
        bus.Funct = 6'($urandom);
        bus.Rd    = 4'($urandom);
      end else begin
        bus.Op    = v.op;
        bus.Funct = v.funct;
        bus.Rd    = v.rd;
      end
      exp_q.push_back(expect_for(v, c, bus.Op));
      @(negedge CLK);
      got = sample();
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL %s cyc%0d: got state=%0d obs=%h, required state=%0d obs=%h",
                 v.name, c, got.state, got, e.state, e);
      end
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    bus.Op = 2'b00; bus.Funct = 6'b0; bus.Rd = 4'b0;

    //   name        op     funct      rd  n  sequence            alu    flagw  pcs_at
    add("LDR R2",   2'b01, 6'b011001, 2,  5, 0, 1, 2, 3, 4,      2'b00, 2'b00, 15);
    add("LDR PC",   2'b01, 6'b011001, 15, 5, 0, 1, 2, 3, 4,      2'b00, 2'b00, 4);
    add("STR",      2'b01, 6'b011000, 3,  4, 0, 1, 2, 5, 0,      2'b00, 2'b00, 15);
    add("STR rd15", 2'b01, 6'b011000, 15, 4, 0, 1, 2, 5, 0,      2'b00, 2'b00, 15);
    add("ADDS PC",  2'b00, 6'b101001, 15, 4, 0, 1, 7, 8, 0,      2'b00, 2'b11, 8);
    add("SUB reg",  2'b00, 6'b000100, 3,  4, 0, 1, 6, 8, 0,      2'b01, 2'b00, 15);
    add("SUBS imm", 2'b00, 6'b100101, 3,  4, 0, 1, 7, 8, 0,      2'b01, 2'b11, 15);
    add("ANDS",     2'b00, 6'b000001, 4,  4, 0, 1, 6, 8, 0,      2'b10, 2'b10, 15);
    add("ORR imm",  2'b00, 6'b111000, 5,  4, 0, 1, 7, 8, 0,      2'b11, 2'b00, 15);
    add("ORRS",     2'b00, 6'b011001, 5,  4, 0, 1, 6, 8, 0,      2'b11, 2'b10, 15);
    add("EORS",     2'b00, 6'b000011, 6,  4, 0, 1, 6, 8, 0,      2'b00, 2'b00, 15);
    add("CMP",      2'b00, 6'b010101, 0,  3, 0, 1, 6, 0, 0,      2'b01, 2'b11, 15);
    add("CMP noS",  2'b00, 6'b010100, 15, 3, 0, 1, 6, 0, 0,      2'b01, 2'b11, 15);
    add("B",        2'b10, 6'b100000, 7,  3, 0, 1, 9, 0, 0,      2'b00, 2'b00, 9);
    add("ILLEGAL",  2'b11, 6'b101001, 15, 2, 0, 1, 0, 0, 0,      2'b00, 2'b00, 15);

    // Reset held: FETCH selects, strobes off
    @(negedge CLK);
    check("rst_state",     8'(bus.State),     8'd0);
    check("rst_irwrite",   8'(bus.IRWrite),   8'd0);
    check("rst_nextpc",    8'(bus.NextPC),    8'd0);
    check("rst_alusrca",   8'(bus.ALUSrcA),   8'd1);
    check("rst_alusrcb",   8'(bus.ALUSrcB),   8'd2);
    check("rst_resultsrc", 8'(bus.ResultSrc), 8'd2);
    @(posedge CLK);
    #1;
    check("rst_hold_state", 8'(bus.State), 8'd0);
    RESET = 1'b0;

    for (int unsigned i = 0; i < vecs.size(); i++)
      run_vec(i, vecs[i].ncyc);

    // Reset in the middle of MEMWRITE
    run_vec(2, 3);
    @(negedge CLK);
    check("mw_state", 8'(bus.State),  8'd5);
    check("mw_memw",  8'(bus.MemW),   8'd1);
    check("mw_adr",   8'(bus.AdrSrc), 8'd1);
    #2;
    RESET = 1'b1;
    #1;
    check("arst_state",   8'(bus.State),   8'd0);
    check("arst_memw",    8'(bus.MemW),    8'd0);
    check("arst_irwrite", 8'(bus.IRWrite), 8'd0);
    check("arst_nextpc",  8'(bus.NextPC),  8'd0);
    check("arst_pcs",     8'(bus.PCS),     8'd0);
    check("arst_adrsrc",  8'(bus.AdrSrc),  8'd0);
    check("arst_alusrca", 8'(bus.ALUSrcA), 8'd1);
    @(posedge CLK);
    #1;
    check("arst_hold_state", 8'(bus.State), 8'd0);
    check("arst_hold_regw",  8'(bus.RegW),  8'd0);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("rel_state",   8'(bus.State),   8'd0);
    check("rel_irwrite", 8'(bus.IRWrite), 8'd1);
    check("rel_nextpc",  8'(bus.NextPC),  8'd1);
    @(posedge CLK);
    #1;
    check("rel_next_state",   8'(bus.State),   8'd1);
    check("rel_next_irwrite", 8'(bus.IRWrite), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
